// File: rtl/fwd_hazard_unit.sv
// Forwarding/hazard unit: shadows in-flight destinations in EX and MEM, registers the EX
// operand-mux selects, raises the IF/ID stall and keeps a saturating stall-cycle counter.
module fwd_hazard_unit #(
   parameter int REG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             freeze,
   input  logic             forward_en,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_use_src1,
   input  logic             id_two_src,
   input  logic             id_wb_en,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_mem_r_en,
   output logic [1:0]       forward1,
   output logic [1:0]       forward2,
   output logic             hazard_stall,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_WB  = 2'b10;

   // The WB slot is not stored: by the time an entry retires the register file holds its
   // value, so nothing downstream of MEM is ever consulted.
   logic             ex_valid;
   logic             ex_wb_en;
   logic             ex_mem_r;
   logic [REG_W-1:0] ex_dest;
   logic             mem_valid;
   logic             mem_wb_en;
   logic [REG_W-1:0] mem_dest;

   logic             ex_hit1;
   logic             ex_hit2;
   logic             mem_hit1;
   logic             mem_hit2;
   logic [1:0]       sel1;
   logic [1:0]       sel2;

   always_comb begin
      ex_hit1  = id_valid & id_use_src1 & ex_valid & ex_wb_en & (ex_dest == id_src1);
      ex_hit2  = id_valid & id_two_src & ex_valid & ex_wb_en & (ex_dest == id_src2);
      mem_hit1 = id_valid & id_use_src1 & mem_valid & mem_wb_en & (mem_dest == id_src1);
      mem_hit2 = id_valid & id_two_src & mem_valid & mem_wb_en & (mem_dest == id_src2);

      // An EX producer moves to MEM alongside the consumer, a MEM producer to WB;
      // the EX check comes first so the newest producer wins.
      sel1 = SEL_RF;
      sel2 = SEL_RF;
      if (forward_en) begin
         if (ex_hit1)
            sel1 = SEL_MEM;
         else if (mem_hit1)
            sel1 = SEL_WB;
         if (ex_hit2)
            sel2 = SEL_MEM;
         else if (mem_hit2)
            sel2 = SEL_WB;
      end

      hazard_stall = 1'b0;
      if (id_valid && !flush) begin
         if (forward_en)
            hazard_stall = (ex_hit1 | ex_hit2) & ex_mem_r;
         else
            hazard_stall = ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2;
      end
   end

   // Flush and stall both drop a bubble into EX; only a stall is counted.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ex_valid    <= 1'b0;
         ex_wb_en    <= 1'b0;
         ex_mem_r    <= 1'b0;
         ex_dest     <= '0;
         mem_valid   <= 1'b0;
         mem_wb_en   <= 1'b0;
         mem_dest    <= '0;
         forward1    <= SEL_RF;
         forward2    <= SEL_RF;
         stall_count <= '0;
      end else if (!freeze) begin
         mem_valid <= ex_valid;
         mem_wb_en <= ex_wb_en;
         mem_dest  <= ex_dest;
         if (flush || hazard_stall) begin
            ex_valid <= 1'b0;
            ex_wb_en <= 1'b0;
            ex_mem_r <= 1'b0;
            ex_dest  <= '0;
            forward1 <= SEL_RF;
            forward2 <= SEL_RF;
         end else begin
            ex_valid <= id_valid;
            ex_wb_en <= id_wb_en;
            ex_mem_r <= id_mem_r_en;
            ex_dest  <= id_dest;
            forward1 <= sel1;
            forward2 <= sel2;
         end
         if (hazard_stall && stall_count != {CNT_W{1'b1}})
            stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios then random traffic, scored against an
// age-based model of in-flight producers; a 4-bit-counter copy exercises saturation.
module tb_fwd_hazard_unit;

   localparam int REG_W = 4;
   localparam int CNT_W = 16;
   localparam int SAT_W = 4;

   typedef struct {
      bit               rst;
      bit               freeze;
      bit               fen;
      bit               flush;
      bit               valid;
      logic [REG_W-1:0] src1;
      logic [REG_W-1:0] src2;
      logic [REG_W-1:0] dest;
      bit               use1;
      bit               two;
      bit               wb;
      bit               load;
   } stim_t;

   typedef struct {
      bit               valid;
      bit               wb;
      bit               load;
      logic [REG_W-1:0] dest;
   } entry_t;

   typedef struct {
      logic [1:0]       f1;
      logic [1:0]       f2;
      logic [CNT_W-1:0] cnt;
      logic [SAT_W-1:0] cnt_sat;
   } regs_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             freeze;
   logic             forward_en;
   logic             flush;
   logic             id_valid;
   logic [REG_W-1:0] id_src1;
   logic [REG_W-1:0] id_src2;
   logic             id_use_src1;
   logic             id_two_src;
   logic             id_wb_en;
   logic [REG_W-1:0] id_dest;
   logic             id_mem_r_en;
   logic [1:0]       forward1;
   logic [1:0]       forward2;
   logic             hazard_stall;
   logic [CNT_W-1:0] stall_count;
   logic [1:0]       sat_forward1;
   logic [1:0]       sat_forward2;
   logic             sat_hazard_stall;
   logic [SAT_W-1:0] sat_stall_count;

   int     checks = 0;
   int     errors = 0;
   entry_t inflight[$];
   bit     hq[$];
   regs_t  rq[$];
   logic [1:0] exp_f1 = 2'b00;
   logic [1:0] exp_f2 = 2'b00;
   int     stalls = 0;
   bit     last_hz = 1'b0;

   fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .CLK(clk), .RST(rst), .freeze(freeze), .forward_en(forward_en), .flush(flush),
      .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1),
      .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
      .id_mem_r_en(id_mem_r_en), .forward1(forward1), .forward2(forward2),
      .hazard_stall(hazard_stall), .stall_count(stall_count)
   );

   fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(SAT_W)) dut_sat (
      .CLK(clk), .RST(rst), .freeze(freeze), .forward_en(forward_en), .flush(flush),
      .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1),
      .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
      .id_mem_r_en(id_mem_r_en), .forward1(sat_forward1), .forward2(sat_forward2),
      .hazard_stall(sat_hazard_stall), .stall_count(sat_stall_count)
   );

   initial forever #5 clk = ~clk;

   task automatic check_output(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, actual, required, $time);
      end
   endtask

   function automatic entry_t bubble();
      entry_t e;
      e.valid = 1'b0;
      e.wb    = 1'b0;
      e.load  = 1'b0;
      e.dest  = '0;
      return e;
   endfunction

   // Age of the newest in-flight writer of src: 1 = just issued, 2 = one older, 0 = none.
   function automatic int producer_age(input logic [REG_W-1:0] src);
      for (int i = 0; i < inflight.size(); i++)
         if (inflight[i].valid && inflight[i].wb && inflight[i].dest == src)
            return i + 1;
      return 0;
   endfunction

   function automatic bit model_hazard(input stim_t s);
      int a1;
      int a2;
      if (!s.valid || s.flush)
         return 1'b0;
      a1 = s.use1 ? producer_age(s.src1) : 0;
      a2 = s.two ? producer_age(s.src2) : 0;
      if (s.fen)
         return (a1 == 1 || a2 == 1) && inflight[0].load;
      return a1 != 0 || a2 != 0;
   endfunction

   function automatic logic [1:0] model_select(input stim_t s, input bit used,
                                               input logic [REG_W-1:0] src);
      int age;
      if (!s.fen || !s.valid || !used)
         return 2'b00;
      age = producer_age(src);
      return (age == 1) ? 2'b01 : (age == 2) ? 2'b10 : 2'b00;
   endfunction

   task automatic model_update(input stim_t s, input bit hz);
      entry_t e;
      if (s.rst) begin
         inflight.delete();
         inflight.push_back(bubble());
         inflight.push_back(bubble());
         exp_f1 = 2'b00;
         exp_f2 = 2'b00;
         stalls = 0;
      end else if (!s.freeze) begin
         e = bubble();
         if (s.flush || hz) begin
            exp_f1 = 2'b00;
            exp_f2 = 2'b00;
         end else begin
            exp_f1  = model_select(s, s.use1, s.src1);
            exp_f2  = model_select(s, s.two, s.src2);
            e.valid = s.valid;
            e.wb    = s.wb;
            e.load  = s.load;
            e.dest  = s.dest;
         end
         inflight.push_front(e);
         void'(inflight.pop_back());
         if (hz)
            stalls++;
      end
   endtask

   task automatic apply_stimulus(input stim_t s);
      bit    hz;
      regs_t r;
      @(negedge clk);
      rst         = s.rst;
      freeze      = s.freeze;
      forward_en  = s.fen;
      flush       = s.flush;
      id_valid    = s.valid;
      id_src1     = s.src1;
      id_src2     = s.src2;
      id_use_src1 = s.use1;
      id_two_src  = s.two;
      id_wb_en    = s.wb;
      id_dest     = s.dest;
      id_mem_r_en = s.load;
      hz = model_hazard(s);
      hq.push_back(hz);
      model_update(s, hz);
      r.f1      = exp_f1;
      r.f2      = exp_f2;
      r.cnt     = (stalls > 65535) ? 16'hFFFF : CNT_W'(stalls);
      r.cnt_sat = (stalls > 15) ? 4'hF : SAT_W'(stalls);
      rq.push_back(r);
      last_hz = hz;
   endtask

   // Re-presents the same ID instruction for as long as the model expects a stall.
   task automatic issue(input stim_t s);
      int guard = 0;
      apply_stimulus(s);
      while (last_hz && guard < 8) begin
         apply_stimulus(s);
         guard++;
      end
   endtask

   function automatic stim_t instr(input bit fen, input int s1, input bit u1, input int s2,
                                   input bit two, input bit wb, input int dst, input bit ld);
      stim_t s;
      s.rst    = 1'b0;
      s.freeze = 1'b0;
      s.flush  = 1'b0;
      s.fen    = fen;
      s.valid  = 1'b1;
      s.src1   = REG_W'(s1);
      s.src2   = REG_W'(s2);
      s.use1   = u1;
      s.two    = two;
      s.wb     = wb;
      s.dest   = REG_W'(dst);
      s.load   = ld;
      return s;
   endfunction

   function automatic stim_t idle(input bit fen);
      stim_t s = instr(fen, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
      s.valid = 1'b0;
      return s;
   endfunction

   initial begin
      bit eh;
      forever begin
         @(negedge clk);
         #2;
         if (hq.size() > 0) begin
            eh = hq.pop_front();
            check_output("hazard_stall", int'(hazard_stall), int'(eh));
            check_output("sat_hazard_stall", int'(sat_hazard_stall), int'(eh));
         end
      end
   end

   initial begin
      regs_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rq.size() > 0) begin
            e = rq.pop_front();
            check_output("forward1", int'(forward1), int'(e.f1));
            check_output("forward2", int'(forward2), int'(e.f2));
            check_output("stall_count", int'(stall_count), int'(e.cnt));
            check_output("sat_forwards", int'({sat_forward1, sat_forward2}), int'({e.f1, e.f2}));
            check_output("sat_stall_count", int'(sat_stall_count), int'(e.cnt_sat));
         end
      end
   end

   initial begin
      stim_t s;
      stim_t c;
      rst = 1'b1; freeze = 1'b0; forward_en = 1'b1; flush = 1'b0; id_valid = 1'b0;
      id_src1 = '0; id_src2 = '0; id_use_src1 = 1'b0; id_two_src = 1'b0;
      id_wb_en = 1'b0; id_dest = '0; id_mem_r_en = 1'b0;
      inflight.push_back(bubble());
      inflight.push_back(bubble());

      s = idle(1'b1);
      s.rst = 1'b1;
      repeat (2) apply_stimulus(s);

      // ALU back-to-back: SUB r2 <- r1, r3 right after ADD r1.
      issue(instr(1, 7, 1, 8, 1, 1, 1, 0));
      issue(instr(1, 1, 1, 3, 1, 1, 2, 0));
      issue(idle(1));
      // Distance-2 dependency through src2.
      issue(instr(1, 7, 1, 8, 1, 1, 1, 0));
      issue(instr(1, 10, 1, 11, 1, 1, 9, 0));
      issue(instr(1, 12, 1, 1, 1, 1, 13, 0));
      // Double producer of r4: the newer one is selected.
      issue(instr(1, 7, 1, 8, 1, 1, 4, 0));
      issue(instr(1, 9, 1, 8, 1, 1, 4, 0));
      issue(instr(1, 4, 1, 8, 1, 1, 14, 0));
      issue(idle(1));
      // Load-use: LDR r5 then ADD r6 <- r5.
      issue(instr(1, 13, 1, 0, 0, 1, 5, 1));
      issue(instr(1, 5, 1, 7, 1, 1, 6, 0));
      issue(idle(1));
      // Stall-only mode with a plain ALU producer.
      issue(instr(0, 7, 1, 8, 1, 1, 1, 0));
      issue(instr(0, 1, 1, 3, 1, 1, 2, 0));
      issue(idle(0));
      issue(idle(0));
      // Freeze held across a load-use stall.
      issue(instr(1, 13, 1, 0, 0, 1, 5, 1));
      c = instr(1, 5, 1, 7, 1, 1, 6, 0);
      s = c;
      s.freeze = 1'b1;
      repeat (3) apply_stimulus(s);
      issue(c);
      issue(idle(1));
      // Flush of an ID instruction that depends on an in-flight load.
      issue(instr(1, 13, 1, 0, 0, 1, 2, 1));
      s = instr(1, 2, 1, 2, 1, 1, 3, 0);
      s.flush = 1'b1;
      apply_stimulus(s);
      issue(idle(1));
      issue(idle(1));
      // Dependent chain in stall-only mode drives the narrow counter into saturation.
      for (int i = 1; i <= 10; i++)
         issue(instr(0, i - 1, 1, 0, 0, 1, i, 0));
      issue(idle(0));
      // Reset arriving in the middle of a load-use stall.
      issue(instr(1, 13, 1, 0, 0, 1, 5, 1));
      c = instr(1, 5, 1, 7, 1, 1, 6, 0);
      apply_stimulus(c);
      s = c;
      s.rst = 1'b1;
      apply_stimulus(s);
      apply_stimulus(c);
      apply_stimulus(idle(1));

      // Random traffic over a small register window so dependencies are frequent.
      s = idle(1);
      for (int n = 0; n < 3000; n++) begin
         if (!last_hz || $urandom_range(0, 9) == 0) begin
            s.valid = ($urandom_range(0, 99) < 85);
            s.src1  = REG_W'($urandom_range(0, 3));
            s.src2  = REG_W'($urandom_range(0, 3));
            s.dest  = REG_W'($urandom_range(0, 3));
            s.use1  = ($urandom_range(0, 9) < 8);
            s.two   = ($urandom_range(0, 1) == 1);
            s.wb    = ($urandom_range(0, 9) < 8);
            s.load  = ($urandom_range(0, 9) < 3);
         end
         if ($urandom_range(0, 19) == 0)
            s.fen = ~s.fen;
         s.rst    = ($urandom_range(0, 199) == 0);
         s.freeze = ($urandom_range(0, 99) < 8);
         s.flush  = ($urandom_range(0, 99) < 8);
         apply_stimulus(s);
      end

      repeat (2) @(negedge clk);
      check_output("scoreboard_drain", hq.size() + rq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Produces the per-stage forwarding selects and the load-use stall that drive the EX stage's operand muxes.
- Keeps its own shadow pipeline of in-flight destinations (EX, MEM, WB slots), fed from ID-stage decode.
- Compares each ID instruction's sources against that pipeline, then registers `forward1`/`forward2` so they are valid while that instruction is in EX.
- Generates `hazard_stall` for the IF/ID registers and counts stall cycles for performance checks.

Parameters:
- `REG_W`, 4, register index width.
- `CNT_W`, 16, stall-counter width.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `freeze` in 1: global memory stall; all state holds.
- `forward_en` in 1: 1 = forwarding mode, 0 = stall-only mode.
- `flush` in 1: branch taken; the ID instruction becomes a bubble.
- `id_valid` in 1: ID holds a real instruction.
- `id_src1` in `REG_W`: Rn index.
- `id_src2` in `REG_W`: Rm (or Rd for stores) index.
- `id_use_src1` in 1: instruction reads Rn.
- `id_two_src` in 1: instruction reads `src2`.
- `id_wb_en` in 1: instruction writes a register.
- `id_dest` in `REG_W`: destination index.
- `id_mem_r_en` in 1: instruction is a load.
- `forward1` out 2: EX Rn select (00 regfile, 01 MEM ALU result, 10 WB value).
- `forward2` out 2: EX Rm select, same encoding.
- `hazard_stall` out 1: hold PC and IF/ID, insert bubble (combinational).
- `stall_count` out `CNT_W`: saturating count of stalled cycles.

Behaviour:
- Slots: EX, MEM, WB. Each slot holds {`valid`, `wb_en`, `dest`, `mem_r`}.
- On reset, all slot `valid` = 0, `forward1` = `forward2` = 00, `stall_count` = 0, and `hazard_stall` = 0 (no valid slots).
- Priority on each edge: `RST` > `freeze` > `flush` > `hazard_stall` > normal.
- A slot entry matches source s when `valid & wb_en & dest == s`, with the source enabled (`id_use_src1` for src1, `id_two_src` for src2), and `id_valid` = 1.
- `hazard_stall`, forwarding mode: asserted when the EX slot matches an enabled source and `EX.mem_r` = 1 (load-use). This costs exactly one bubble; on the next cycle the load sits in MEM and is forwarded from WB.
- `hazard_stall`, stall-only mode: asserted when the EX slot or the MEM slot matches an enabled source.
- `hazard_stall` is forced to 0 when `flush` = 1 or `id_valid` = 0.
- Select computed at ID, forwarding mode, per source:
  - EX-slot match → 01 (the producer will be in MEM next cycle).
  - Otherwise MEM-slot match → 10.
  - Otherwise 00.
  - The newest producer wins when both slots match.
- Select computed at ID, stall-only mode: always 00.
- Normal edge (no freeze, flush or stall):
  - WB ← MEM, MEM ← EX.
  - EX ← {`id_valid`, `id_wb_en`, `id_dest`, `id_mem_r_en`}.
  - `forward1`/`forward2` ← computed selects.
- Stall edge:
  - WB ← MEM, MEM ← EX.
  - EX ← bubble (`valid` = 0).
  - Forwards ← 00.
  - `stall_count` increments, saturating at all-ones (no wrap).
- Flush edge: same as a stall edge, except `stall_count` does not increment.
- Freeze: every register holds, including the counter. `hazard_stall` still reflects current slots and inputs.
- Select encoding 11 is never produced.
- `forward_en` is sampled each cycle. Toggling it mid-stream takes effect on the next ID evaluation.
- WB slot: it retires, and the register file has written by then, so it is never a forward source.
- Reset mid-stall clears everything in the same edge.

Test Plan:
- ALU back-to-back: `ADD` r1 ← …, then `SUB` r2 ← r1, r3, `forward_en` = 1. Required: the cycle after the SUB accept, `forward1` = 01, `forward2` = 00, `hazard_stall` never 1.
- Distance-2 dependency: r1 producer, unrelated instruction, then a consumer reading r1 as src2. Required: `forward2` = 10 when the consumer is in EX.
- Double producer: r4 written by two consecutive instructions, then a consumer of r4. Required: `forward1` = 01 (the newest producer).
- Load-use: `LDR` r5, then `ADD` r6 ← r5. Required:
  - `hazard_stall` = 1 for exactly one cycle, and `stall_count` goes 0→1.
  - Next edge: forwards = 00 (bubble).
  - Following edge: `forward1` = 10.
- Stall-only mode (`forward_en` = 0): consumer directly after a producer. Required: `hazard_stall` = 1 for 2 cycles, all forwards 00, `stall_count` = 2.
- Freeze/flush/reset corners:
  - `freeze` = 1 for 3 cycles during a load-use stall: selects and `stall_count` unchanged.
  - `flush` with a matching ID instruction: `hazard_stall` = 0, EX bubble inserted.
  - Counter preloaded to 0xFFFF plus a stall: stays 0xFFFF.
  - `RST` during a stall: all outputs 0.
